shift_register_ctrl: RTL and testbench
======================================

SHIFT_REGISTER_CTRL -- requirements
Module: shift_register_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 4, meaning the data width of the controlled shift_register.
REQ-002 SHALL have parameter CNT_W, default 3, meaning the width of the shift-count field.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port clr  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port cmd_valid  input  1  command offered.
REQ-006 SHALL have port cmd_ready  output  1  controller accepts a command this cycle.
REQ-007 SHALL have port cmd_op  input  2  operation: 00 CLEAR, 01 SHIFT RIGHT, 10 SHIFT LEFT, 11 LOAD.
REQ-008 SHALL have port cmd_load  input  1  for shift ops, load cmd_data before shifting.
REQ-009 SHALL have port cmd_rot  input  1  for shift ops, rotate instead of fill.
REQ-010 SHALL have port cmd_fill  input  1  serial fill bit for non-rotating shifts.
REQ-011 SHALL have port cmd_count  input  CNT_W  number of shift cycles, 0..2^CNT_W-1.
REQ-012 SHALL have port cmd_data  input  WIDTH  parallel load value.
REQ-013 SHALL have port sr_q  input  WIDTH  q output of the controlled shift_register.
REQ-014 SHALL have ports sr_s1, sr_s0, sr_r_in, sr_l_in, sr_clr  output  1 each  shift_register mode, serial inputs and active-low clear.
REQ-015 SHALL have port sr_d  output  WIDTH  shift_register parallel input.
REQ-016 SHALL have ports busy, done  output  1 each; result  output  WIDTH  sr_q captured at completion.

Function
REQ-017 SHALL implement states IDLE, CLR, LOAD, SHIFT, DONE; cmd_ready = 1 only in IDLE; busy = 1 in all other states.
REQ-018 SHALL accept a command on a rising edge with cmd_valid && cmd_ready; command fields are registered at acceptance and later input changes are ignored.
REQ-019 SHALL transition on acceptance: CLEAR -> CLR; LOAD -> LOAD; SHIFT with cmd_load=1 -> LOAD; SHIFT with cmd_load=0 and count>0 -> SHIFT; SHIFT with cmd_load=0 and count=0 -> DONE.
REQ-020 CLR SHALL last one cycle with sr_clr=0, {sr_s1,sr_s0}=00, then go to DONE.
REQ-021 LOAD SHALL last one cycle with {sr_s1,sr_s0}=11 and sr_d=registered data, then go to SHIFT if a shift op with count>0, else DONE.
REQ-022 SHIFT SHALL last exactly count cycles with {sr_s1,sr_s0}=01 (right) or 10 (left), decrementing an internal counter; it goes to DONE when the counter reaches 1.
REQ-023 Shift right SHALL drive sr_r_in (moves q[i+1]->q[i], sr_r_in->q[WIDTH-1]); shift left SHALL drive sr_l_in (q[i]->q[i+1], sr_l_in->q[0]); the unused serial input is 0.
REQ-024 Non-rotating shifts SHALL drive the active serial input with registered cmd_fill.
REQ-025 DONE SHALL last one cycle with done=1 and capture result <= sr_q at its end; result holds until the next DONE; then go to IDLE.
REQ-026 Total latency SHALL be (LOAD?1:0) + (CLR?1:0) + count + 1 cycles from the acceptance edge to done high; the next command is accepted no earlier than the cycle after done.
REQ-027 Outside CLR/LOAD/SHIFT the controller SHALL drive {sr_s1,sr_s0}=00, sr_clr=1, sr_r_in=sr_l_in=0, sr_d=0 (hold).
REQ-028 SHIFT with count=0 and cmd_load=1 SHALL perform only the load.

Reset
REQ-029 clr low SHALL immediately force IDLE, counter 0, result 0, done 0, busy 0, cmd_ready 0 while low, and the hold/idle values of REQ-027.
REQ-030 sr_clr SHALL be driven low combinationally while clr is low, so that the shift_register clears with the controller.
REQ-031 Reset asserted mid-operation SHALL abort the command with no done pulse; cmd_ready = 1 on the first edge after clr deasserts.

Configuration
REQ-032 Macro SHIFT_REGISTER_CTRL_ROTATE_EN: when defined, cmd_rot=1 SHALL drive sr_r_in=sr_q[0] (right) or sr_l_in=sr_q[WIDTH-1] (left) each SHIFT cycle; when undefined, cmd_rot SHALL be ignored and cmd_fill is always used.

Verification
REQ-033 LOAD with data=1011 -> sr_s1,sr_s0=11 for 1 cycle, done 2 cycles after acceptance, result=1011.
REQ-034 SHIFT RIGHT with load=1, data=1000, fill=1, count=2 -> 1 LOAD + 2 SHIFT cycles, done at cycle 4, result=1110.
REQ-035 SHIFT LEFT with load=0, fill=0, count=0, sr_q=0101 -> done at cycle 1, result=0101, sr mode stays 00.
REQ-036 ROTATE_EN defined, SHIFT LEFT with load=1, data=1001, rot=1, count=1 -> result=0011; macro undefined with fill=0 -> result=0010.
REQ-037 clr pulsed low during SHIFT with count=5 -> sr_clr low immediately, no done, result=0000, cmd_ready=1 after release.
REQ-038 CLEAR with sr_q=1111 -> sr_clr=0 for one cycle, done 2 cycles after acceptance, result=0000; cmd_valid held high shows back-to-back acceptance only after done.

Source files
------------

// File: rtl/shift_register_ctrl.sv
// Sequencer that drives an external 4-mode shift_register through clear, load and shift steps.
// Optional build macro SHIFT_REGISTER_CTRL_ROTATE_EN enables rotating shifts via cmd_rot.
module shift_register_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic             cmd_load,
  input  logic             cmd_rot,
  input  logic             cmd_fill,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [WIDTH-1:0] sr_q,
  output logic             sr_s1,
  output logic             sr_s0,
  output logic             sr_r_in,
  output logic             sr_l_in,
  output logic             sr_clr,
  output logic [WIDTH-1:0] sr_d,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  typedef enum logic [2:0] {S_IDLE, S_CLR, S_LOAD, S_SHIFT, S_DONE} state_t;

  // Command opcodes share their encoding with the shift_register mode pins.
  localparam logic [1:0] OP_CLEAR = 2'b00;
  localparam logic [1:0] OP_RIGHT = 2'b01;
  localparam logic [1:0] OP_LEFT  = 2'b10;
  localparam logic [1:0] OP_LOAD  = 2'b11;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic             rot_q, rot_d;
  logic             fill_q, fill_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic [1:0] sr_mode;
  logic       sr_clr_c;
  logic       rot_req;
  logic       shift_in;
  logic       is_shift_q;

`ifdef SHIFT_REGISTER_CTRL_ROTATE_EN
  assign rot_req  = cmd_rot;
  assign shift_in = rot_q ? ((op_q == OP_RIGHT) ? sr_q[0] : sr_q[WIDTH-1]) : fill_q;
`else
  logic unused_rot;
  assign unused_rot = cmd_rot ^ rot_q;
  assign rot_req    = 1'b0;
  assign shift_in   = fill_q;
`endif

  assign is_shift_q = (op_q == OP_RIGHT) || (op_q == OP_LEFT);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d  = state_q;
    op_d     = op_q;
    rot_d    = rot_q;
    fill_d   = fill_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    result_d = result_q;
    sr_mode  = 2'b00;
    sr_d     = '0;
    sr_r_in  = 1'b0;
    sr_l_in  = 1'b0;
    sr_clr_c = 1'b1;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d   = cmd_op;
          rot_d  = rot_req;
          fill_d = cmd_fill;
          cnt_d  = cmd_count;
          data_d = cmd_data;
          if (cmd_op == OP_CLEAR)                 state_d = S_CLR;
          else if (cmd_op == OP_LOAD || cmd_load) state_d = S_LOAD;
          else if (cmd_count != '0)               state_d = S_SHIFT;
          else                                    state_d = S_DONE;
        end
      end
      S_CLR: begin
        sr_clr_c = 1'b0;
        state_d  = S_DONE;
      end
      S_LOAD: begin
        sr_mode = OP_LOAD;
        sr_d    = data_q;
        state_d = (is_shift_q && cnt_q != '0) ? S_SHIFT : S_DONE;
      end
      S_SHIFT: begin
        sr_mode = op_q;
        if (op_q == OP_RIGHT) sr_r_in = shift_in;
        else                  sr_l_in = shift_in;
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) state_d = S_DONE;
      end
      S_DONE: begin
        result_d = sr_q;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q  <= S_IDLE;
      op_q     <= OP_CLEAR;
      rot_q    <= 1'b0;
      fill_q   <= 1'b0;
      cnt_q    <= '0;
      data_q   <= '0;
      result_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so all state updates see pre-edge values.
      state_q  <= state_d;
      op_q     <= op_d;
      rot_q    <= rot_d;
      fill_q   <= fill_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      result_q <= result_d;
    end
  end

  assign {sr_s1, sr_s0} = sr_mode;
  // The controlled register clears together with the controller.
  assign sr_clr    = clr & sr_clr_c;
  assign cmd_ready = clr & (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign result    = result_q;

endmodule

// File: tb/tb_shift_register_ctrl.sv
// Randomized bench for shift_register_ctrl: drives commands into the controller plus a model
// shift_register, and checks results/latency/mode usage against an arithmetic reference.
module tb_shift_register_ctrl;

  localparam int WIDTH = 4;
  localparam int CNT_W = 3;
  localparam int MASK  = (1 << WIDTH) - 1;
`ifdef SHIFT_REGISTER_CTRL_ROTATE_EN
  localparam bit ROT_EN = 1'b1;
`else
  localparam bit ROT_EN = 1'b0;
`endif

  logic             clk;
  logic             clr;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic             cmd_load;
  logic             cmd_rot;
  logic             cmd_fill;
  logic [CNT_W-1:0] cmd_count;
  logic [WIDTH-1:0] cmd_data;
  logic [WIDTH-1:0] sr_q;
  logic             sr_s1, sr_s0, sr_r_in, sr_l_in, sr_clr;
  logic [WIDTH-1:0] sr_d;
  logic             busy, done;
  logic [WIDTH-1:0] result;

  shift_register_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .clr(clr),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_load(cmd_load), .cmd_rot(cmd_rot), .cmd_fill(cmd_fill),
    .cmd_count(cmd_count), .cmd_data(cmd_data),
    .sr_q(sr_q), .sr_s1(sr_s1), .sr_s0(sr_s0), .sr_r_in(sr_r_in), .sr_l_in(sr_l_in),
    .sr_clr(sr_clr), .sr_d(sr_d),
    .busy(busy), .done(done), .result(result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The controlled shift_register: 00 hold, 01 right, 10 left, 11 load, async active-low clear.
  always_ff @(posedge clk or negedge sr_clr) begin
    if (!sr_clr) sr_q <= '0;
    else begin
      case ({sr_s1, sr_s0})
        2'b01:   sr_q <= {sr_r_in, sr_q[WIDTH-1:1]};
        2'b10:   sr_q <= {sr_q[WIDTH-2:0], sr_l_in};
        2'b11:   sr_q <= sr_d;
        default: sr_q <= sr_q;
      endcase
    end
  end

  int n_vec = 0;
  int n_err = 0;
  logic [WIDTH-1:0] model_val;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int ref_result(input int op, input bit load, input bit rot, input bit fill,
                                    input int cnt, input int data, input int start);
    int v;
    int b;
    if (op == 0) return 0;
    if (op == 3) return data;
    v = load ? data : start;
    for (int i = 0; i < cnt; i++) begin
      if (op == 1) begin
        b = (ROT_EN && rot) ? (v & 1) : int'(fill);
        v = (v >> 1) | (b << (WIDTH - 1));
      end else begin
        b = (ROT_EN && rot) ? ((v >> (WIDTH - 1)) & 1) : int'(fill);
        v = ((v << 1) | b) & MASK;
      end
    end
    return v;
  endfunction

  task automatic scramble();
    cmd_op    = 2'($urandom);
    cmd_load  = 1'($urandom);
    cmd_rot   = 1'($urandom);
    cmd_fill  = 1'($urandom);
    cmd_count = CNT_W'($urandom);
    cmd_data  = WIDTH'($urandom);
  endtask

  task automatic do_cmd(input int op, input bit load, input bit rot, input bit fill, input int cnt,
                        input int data, input bit hold, input string tag);
    bit is_shift;
    int exp_res, exp_lat, exp_nload, exp_nshift, exp_nclr;
    int lat, n_load, n_shift, n_clr, n_bad, w;
    is_shift   = (op == 1) || (op == 2);
    exp_res    = ref_result(op, load, rot, fill, cnt, data, int'(model_val));
    exp_lat    = is_shift ? (int'(load) + cnt + 1) : 2;
    exp_nload  = (op == 3 || (is_shift && load)) ? 1 : 0;
    exp_nshift = is_shift ? cnt : 0;
    exp_nclr   = (op == 0) ? 1 : 0;

    cmd_op    = 2'(op);
    cmd_load  = load;
    cmd_rot   = rot;
    cmd_fill  = fill;
    cmd_count = CNT_W'(cnt);
    cmd_data  = WIDTH'(data);
    cmd_valid = 1'b1;
    w = 0;
    while (!cmd_ready && w < 20) begin
      step();
      w++;
    end
    if (!cmd_ready) begin
      check({tag, "/ready_timeout"}, 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b0;
      return;
    end
    step();
    if (!hold) cmd_valid = 1'b0;
    scramble();

    lat = 0; n_load = 0; n_shift = 0; n_clr = 0; n_bad = 0;
    for (int k = 1; k <= 40; k++) begin
      if ({sr_s1, sr_s0} == 2'b11) n_load++;
      else if ({sr_s1, sr_s0} != 2'b00) begin
        if ({sr_s1, sr_s0} == 2'(op)) n_shift++;
        else n_bad++;
      end
      if (!sr_clr) n_clr++;
      if ({sr_s1, sr_s0} != 2'b11 && sr_d != '0) n_bad++;
      if ({sr_s1, sr_s0} != 2'b01 && sr_r_in) n_bad++;
      if ({sr_s1, sr_s0} != 2'b10 && sr_l_in) n_bad++;
      if (!busy || cmd_ready) n_bad++;
      if (done) begin
        lat = k;
        break;
      end
      step();
    end
    check({tag, "/latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "/load_cycles"}, 32'(n_load), 32'(exp_nload));
    check({tag, "/shift_cycles"}, 32'(n_shift), 32'(exp_nshift));
    check({tag, "/clr_cycles"}, 32'(n_clr), 32'(exp_nclr));
    check({tag, "/bad_drive"}, 32'(n_bad), 32'd0);
    step();
    check({tag, "/result"}, 32'(result), 32'(exp_res));
    check({tag, "/idle_ready"}, {busy, done, cmd_ready}, 32'b001);
    model_val = WIDTH'(exp_res);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int saw_done;
    clr       = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_load  = 1'b0;
    cmd_rot   = 1'b0;
    cmd_fill  = 1'b0;
    cmd_count = '0;
    cmd_data  = '0;
    #12;
    check("reset/ready_busy_done", {cmd_ready, busy, done}, 32'b000);
    check("reset/result", 32'(result), 32'd0);
    check("reset/sr_clr", 32'(sr_clr), 32'd0);
    check("reset/hold_drive", {sr_s1, sr_s0, sr_r_in, sr_l_in, sr_d}, 32'd0);
    @(posedge clk);
    #3 clr = 1'b1;
    step();
    check("post_reset/ready", {cmd_ready, busy, sr_clr}, 32'b101);
    model_val = '0;

    do_cmd(3, 0, 0, 0, 0, 4'b1011, 0, "load1011");
    do_cmd(1, 1, 0, 1, 2, 4'b1000, 0, "shr_load_fill");
    do_cmd(3, 0, 0, 0, 5, 4'b0101, 0, "load0101");
    do_cmd(2, 0, 0, 0, 0, 4'b1111, 0, "shl_cnt0");
    do_cmd(2, 1, 1, 0, 1, 4'b1001, 0, "shl_rot");
    do_cmd(1, 1, 1, 1, 3, 4'b0110, 0, "shr_rot");
    do_cmd(2, 1, 0, 1, 0, 4'b0100, 0, "shl_load_cnt0");
    do_cmd(3, 0, 0, 0, 0, 4'b1111, 0, "load1111");
    do_cmd(0, 1, 0, 1, 7, 4'b1010, 1, "clear_b2b");
    do_cmd(3, 0, 0, 0, 0, 4'b0110, 0, "after_clear");

    // Abort a long shift with reset; the command must vanish without a done pulse.
    cmd_op = 2'b01; cmd_load = 1'b0; cmd_rot = 1'b0; cmd_fill = 1'b1;
    cmd_count = CNT_W'(5); cmd_data = 4'b0000; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    step();
    step();
    #3 clr = 1'b0;
    #1;
    check("abort/sr_clr", 32'(sr_clr), 32'd0);
    check("abort/ready_busy_done", {cmd_ready, busy, done}, 32'b000);
    check("abort/result", 32'(result), 32'd0);
    saw_done = 0;
    for (int i = 0; i < 2; i++) begin
      step();
      if (done) saw_done++;
    end
    #2 clr = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      if (done) saw_done++;
    end
    check("abort/no_done", 32'(saw_done), 32'd0);
    check("abort/ready_after", {cmd_ready, busy}, 32'b10);
    check("abort/sr_q_cleared", 32'(sr_q), 32'd0);
    model_val = '0;

    for (int i = 0; i < 40; i++) begin
      do_cmd(int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), 1'($urandom),
             int'($urandom_range(0, (1 << CNT_W) - 1)), int'($urandom_range(0, MASK)),
             (i != 39) && 1'($urandom), "rand");
    end
    cmd_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
